// File: rtl/bswap_engine_pkg.sv
// -----------------------------------------------------------------------------
// bswap_engine_pkg
// Shared types and helpers for the bswap executor.
//   ADDR_W / LEN_W : word-address width and length/counter width
//   bswap_a        : command record (first word address, word count)
//   bswap_o()      : builds a bswap_a from its two fields
//   bswap()        : byte-reverses one 32-bit word
//   bswap_state_e  : engine FSM states
// -----------------------------------------------------------------------------
package bswap_engine_pkg;

   localparam int ADDR_W = 32;
   localparam int LEN_W  = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] arr_1;
      logic [LEN_W-1:0]  length;
   } bswap_a;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } bswap_state_e;

   function automatic bswap_a bswap_o(input logic [ADDR_W-1:0] arr_1,
                                      input logic [LEN_W-1:0]  length);
      bswap_a cmd;
      cmd.arr_1  = arr_1;
      cmd.length = length;
      return cmd;
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage

// File: rtl/bswap_engine_if.sv
// -----------------------------------------------------------------------------
// bswap_engine_if
// Bundles the dispatcher command handshake, the exe_env u32 memory port and
// the status flags of the bswap executor.
//   master : dispatcher/memory side (drives the command and read data)
//   slave  : the engine (drives ready, memory strobes, busy, done)
// -----------------------------------------------------------------------------
interface bswap_engine_if;
   import bswap_engine_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_arr_1;
   logic [LEN_W-1:0]  cmd_length;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [31:0]       mem_rd_data;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [31:0]       mem_wr_data;
   logic              busy;
   logic              done;

   modport master (
      output cmd_valid, cmd_arr_1, cmd_length, mem_rd_data,
      input  cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
             mem_wr_data, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_arr_1, cmd_length, mem_rd_data,
      output cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
             mem_wr_data, busy, done
   );

endinterface

// File: rtl/bswap_engine_wr_stage.sv
// -----------------------------------------------------------------------------
// bswap_engine_wr_stage
// Write half of the read->write pipeline. Remembers which read was issued last
// cycle and writes the byte-reversed returning word back to the same address.
//   clk, rst   : clock, asynchronous active-high reset
//   i_rdEn     : read issued this cycle
//   i_rdAddr   : address of that read
//   i_rdData   : memory read data (valid one cycle after i_rdEn)
//   o_wrEn     : write strobe
//   o_wrAddr   : write address
//   o_wrData   : byte-swapped word
// -----------------------------------------------------------------------------
module bswap_engine_wr_stage
   import bswap_engine_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rdEn,
   input  logic [ADDR_W-1:0] i_rdAddr,
   input  logic [31:0]       i_rdData,
   output logic              o_wrEn,
   output logic [ADDR_W-1:0] o_wrAddr,
   output logic [31:0]       o_wrData
);

   logic              r_rdValid;
   logic [ADDR_W-1:0] r_wrAddr;

   // Delay the read strobe and address by one cycle so they line up with the
   // data coming back from memory; reset kills any pending write at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdValid <= 1'b0;
         r_wrAddr  <= '0;
      end else begin
         r_rdValid <= i_rdEn;
         r_wrAddr  <= i_rdAddr;
      end
   end

   // Write data is gated so the bus reads as zero whenever no write is issued.
   assign o_wrEn   = r_rdValid;
   assign o_wrAddr = r_wrAddr;
   assign o_wrData = r_rdValid ? bswap(i_rdData) : '0;

endmodule

// File: rtl/bswap_engine.sv
// -----------------------------------------------------------------------------
// bswap_engine
// Sequential executor for the bswap operation: accepts (arr_1, length), reads
// length consecutive u32 words starting at arr_1 (wrapping at 2**ADDR_W),
// and writes each back byte-reversed in place, one word per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bswap_engine_if.slave (command handshake, memory port,
//              busy, done)
// -----------------------------------------------------------------------------
module bswap_engine
   import bswap_engine_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   bswap_engine_if.slave bus
);

   bswap_state_e      r_state;
   bswap_state_e      w_nextState;
   bswap_a            w_cmd;
   logic [ADDR_W-1:0] r_rdAddr;
   logic [LEN_W-1:0]  r_remain;
   logic              w_accept;
   logic              w_cmdReady;
   logic              w_busy;
   logic              w_done;
   logic              w_rdEn;
   logic              w_wrEn;
   logic [ADDR_W-1:0] w_wrAddr;
   logic [31:0]       w_wrData;

   assign w_cmd    = bswap_o(bus.cmd_arr_1, bus.cmd_length);
   assign w_accept = bus.cmd_valid && w_cmdReady;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. A zero-length command skips straight to DONE so it
   // produces no memory traffic. RUN leaves after the read whose remaining
   // count is 1, which also lets the full 2**LEN_W-1 range work.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = (w_cmd.length == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (r_remain == LEN_W'(1)) begin
               w_nextState = DRAIN;
            end
         end
         DRAIN:   w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Outputs decoded purely from the current state.
   always_comb begin
      w_cmdReady = 1'b0;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      w_rdEn     = 1'b0;
      case (r_state)
         IDLE:  w_cmdReady = 1'b1;
         RUN: begin
            w_busy = 1'b1;
            w_rdEn = 1'b1;
         end
         DRAIN: w_busy = 1'b1;
         DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
         end
         default: w_cmdReady = 1'b0;
      endcase
   end

   // Read address generator and remaining-word down-counter. The address
   // simply increments and so wraps naturally at 2**ADDR_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdAddr <= '0;
         r_remain <= '0;
      end else if (w_accept) begin
         r_rdAddr <= w_cmd.arr_1;
         r_remain <= w_cmd.length;
      end else if (r_state == RUN) begin
         r_rdAddr <= r_rdAddr + ADDR_W'(1);
         r_remain <= r_remain - LEN_W'(1);
      end
   end

   bswap_engine_wr_stage u_wrStage (
      .clk      (clk),
      .rst      (rst),
      .i_rdEn   (w_rdEn),
      .i_rdAddr (r_rdAddr),
      .i_rdData (bus.mem_rd_data),
      .o_wrEn   (w_wrEn),
      .o_wrAddr (w_wrAddr),
      .o_wrData (w_wrData)
   );

   assign bus.cmd_ready   = w_cmdReady;
   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.mem_rd_en   = w_rdEn;
   assign bus.mem_rd_addr = r_rdAddr;
   assign bus.mem_wr_en   = w_wrEn;
   assign bus.mem_wr_addr = w_wrAddr;
   assign bus.mem_wr_data = w_wrData;

endmodule

// File: tb/tb_bswap_engine.sv
// -----------------------------------------------------------------------------
// tb_bswap_engine
// Drives bswap_engine through directed and random commands against a word
// memory model and an expected memory image built from the byte-reversal rule.
// -----------------------------------------------------------------------------
module tb_bswap_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bswap_engine_if bus ();

   bswap_engine dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem    [logic [31:0]];
   logic [31:0] expMem [logic [31:0]];
   logic [31:0] wrLog  [$];
   int          acceptLog [$];
   int          cycleCount = 0;
   int          rdCount    = 0;
   int          wrCount    = 0;
   int          doneCount  = 0;
   int          passCount  = 0;
   int          checkCount = 0;

   initial begin
      bus.cmd_valid   = 1'b0;
      bus.cmd_arr_1   = '0;
      bus.cmd_length  = '0;
      bus.mem_rd_data = '0;
   end

   function automatic logic [31:0] memRead(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] expRead(input logic [31:0] a);
      return expMem.exists(a) ? expMem[a] : 32'h0;
   endfunction

   // Reference byte reversal: byte b of the input lands in byte 3-b.
   function automatic logic [31:0] refSwap(input logic [31:0] w);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 4; b++) r[8*(3-b) +: 8] = w[8*b +: 8];
      return r;
   endfunction

   // Functional model of one command applied to the expected image.
   function automatic void applyModel(input logic [31:0] arr, input logic [31:0] len);
      logic [31:0] a;
      a = arr;
      for (int i = 0; i < int'(len); i++) begin
         expMem[a] = refSwap(expRead(a));
         a = a + 32'd1;
      end
   endfunction

   // Counts addresses where memory and the expected image disagree, including
   // any address written that the model never touched.
   function automatic int imageDiffs();
      int n;
      n = 0;
      foreach (expMem[k]) if (memRead(k) !== expMem[k]) n++;
      foreach (mem[k]) if (!expMem.exists(k)) n++;
      return n;
   endfunction

   function automatic void preload(input logic [31:0] a, input logic [31:0] v);
      mem[a]    = v;
      expMem[a] = v;
   endfunction

   // Synchronous word memory plus event monitors.
   always @(posedge clk) begin
      cycleCount++;
      if (bus.mem_wr_en === 1'b1) begin
         mem[bus.mem_wr_addr] = bus.mem_wr_data;
         wrLog.push_back(bus.mem_wr_addr);
         wrCount++;
      end
      if (bus.mem_rd_en === 1'b1) begin
         bus.mem_rd_data <= memRead(bus.mem_rd_addr);
         rdCount++;
      end
      if (bus.done === 1'b1) doneCount++;
      if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) acceptLog.push_back(cycleCount - 1);
   end

   // Offers one command and returns the cycle number in which it was accepted.
   task automatic applyStimulus(input logic [31:0] arr, input logic [31:0] len,
                                output int acceptCycle);
      @(negedge clk);
      bus.cmd_valid  = 1'b1;
      bus.cmd_arr_1  = arr;
      bus.cmd_length = len;
      for (int k = 0; k < 200 && bus.cmd_ready !== 1'b1; k++) @(negedge clk);
      acceptCycle = cycleCount;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic waitDone(input int budget, output int doneCycle, output bit seen);
      seen      = 1'b0;
      doneCycle = -1;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen      = 1'b1;
            doneCycle = cycleCount;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checkCount++;
      if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready got %b want 1", bus.cmd_ready);
      else passCount++;
      checkCount++;
      if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", bus.busy);
      else passCount++;
      checkCount++;
      if (bus.done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", bus.done);
      else passCount++;
      checkCount++;
      if ({bus.mem_rd_en, bus.mem_wr_en} !== 2'b00)
         $display("[TB] FAIL reset_strobes got %b want 00", {bus.mem_rd_en, bus.mem_wr_en});
      else passCount++;
      checkCount++;
      if ({bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data} !== 96'h0)
         $display("[TB] FAIL reset_addr_data got %h want 0", {bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data});
      else passCount++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int acc, dn, rd0, wr0;
      bit seen;
      logic [31:0] want [5];
      mem.delete(); expMem.delete();
      preload(32'd3, 32'h5555AAAA);
      preload(32'd4, 32'h11223344);
      preload(32'd5, 32'hAABBCCDD);
      preload(32'd6, 32'h00000001);
      preload(32'd7, 32'h12345678);
      want = '{32'h5555AAAA, 32'h44332211, 32'hDDCCBBAA, 32'h01000000, 32'h12345678};
      rd0 = rdCount; wr0 = wrCount;
      applyStimulus(32'd4, 32'd3, acc);
      waitDone(50, dn, seen);
      checkCount++;
      if (!seen || dn - acc != 5) $display("[TB] FAIL basic_latency got %0d want 5", seen ? dn - acc : -1);
      else passCount++;
      for (int i = 0; i < 5; i++) begin
         checkCount++;
         if (memRead(32'(3 + i)) !== want[i])
            $display("[TB] FAIL basic_mem[%0d] got %h want %h", 3 + i, memRead(32'(3 + i)), want[i]);
         else passCount++;
      end
      checkCount++;
      if (rdCount - rd0 != 3 || wrCount - wr0 != 3)
         $display("[TB] FAIL basic_traffic got rd=%0d wr=%0d want 3/3", rdCount - rd0, wrCount - wr0);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1)
         $display("[TB] FAIL basic_idle_after_done got busy=%b ready=%b want 0/1", bus.busy, bus.cmd_ready);
      else passCount++;
   endtask

   task automatic test_zero_length();
      int acc, dn, rd0, wr0;
      bit seen;
      rd0 = rdCount; wr0 = wrCount;
      applyStimulus(32'd10, 32'd0, acc);
      waitDone(20, dn, seen);
      checkCount++;
      if (!seen || dn - acc != 1) $display("[TB] FAIL zero_latency got %0d want 1", seen ? dn - acc : -1);
      else passCount++;
      checkCount++;
      if (rdCount - rd0 != 0 || wrCount - wr0 != 0)
         $display("[TB] FAIL zero_traffic got rd=%0d wr=%0d want 0/0", rdCount - rd0, wrCount - wr0);
      else passCount++;
   endtask

   task automatic test_wrap();
      int acc, dn;
      bit seen;
      logic [31:0] wantAddr [4];
      wantAddr = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      mem.delete(); expMem.delete(); wrLog.delete();
      for (int i = 0; i < 4; i++) preload(wantAddr[i], $urandom);
      applyModel(32'hFFFFFFFE, 32'd4);
      applyStimulus(32'hFFFFFFFE, 32'd4, acc);
      waitDone(50, dn, seen);
      checkCount++;
      if (!seen || dn - acc != 6) $display("[TB] FAIL wrap_latency got %0d want 6", seen ? dn - acc : -1);
      else passCount++;
      checkCount++;
      if (wrLog.size() != 4) $display("[TB] FAIL wrap_write_count got %0d want 4", wrLog.size());
      else passCount++;
      for (int i = 0; i < 4 && i < wrLog.size(); i++) begin
         checkCount++;
         if (wrLog[i] !== wantAddr[i]) $display("[TB] FAIL wrap_addr[%0d] got %h want %h", i, wrLog[i], wantAddr[i]);
         else passCount++;
      end
      checkCount++;
      if (imageDiffs() != 0) $display("[TB] FAIL wrap_image got %0d diffs want 0", imageDiffs());
      else passCount++;
   endtask

   task automatic test_back_to_back();
      int dn1, dn2, base, k;
      bit seen;
      mem.delete(); expMem.delete();
      for (int i = 20; i < 25; i++) preload(32'(i), $urandom);
      applyModel(32'd20, 32'd5);
      applyModel(32'd20, 32'd5);
      base = acceptLog.size();
      @(negedge clk);
      bus.cmd_valid  = 1'b1;
      bus.cmd_arr_1  = 32'd20;
      bus.cmd_length = 32'd5;
      waitDone(50, dn1, seen);
      checkCount++;
      if (!seen) $display("[TB] FAIL b2b_first_done got none want pulse");
      else passCount++;
      for (k = 0; k < 20 && acceptLog.size() < base + 2; k++) @(negedge clk);
      bus.cmd_valid = 1'b0;
      checkCount++;
      if (acceptLog.size() != base + 2 || acceptLog[base + 1] != dn1 + 1)
         $display("[TB] FAIL b2b_second_accept got cycle %0d want %0d",
                  acceptLog.size() > base + 1 ? acceptLog[base + 1] : -1, dn1 + 1);
      else passCount++;
      waitDone(50, dn2, seen);
      checkCount++;
      if (!seen) $display("[TB] FAIL b2b_second_done got none want pulse");
      else passCount++;
      repeat (3) @(negedge clk);
      checkCount++;
      if (acceptLog.size() != base + 2) $display("[TB] FAIL b2b_accept_count got %0d want 2", acceptLog.size() - base);
      else passCount++;
      checkCount++;
      if (imageDiffs() != 0) $display("[TB] FAIL b2b_image got %0d diffs want 0", imageDiffs());
      else passCount++;
   endtask

   task automatic test_reset_mid();
      int acc, done0, wr0;
      logic [31:0] orig [8];
      mem.delete(); expMem.delete();
      for (int i = 0; i < 8; i++) begin
         orig[i] = $urandom;
         preload(32'(40 + i), orig[i]);
      end
      expMem[32'd40] = refSwap(orig[0]);
      expMem[32'd41] = refSwap(orig[1]);
      done0 = doneCount;
      applyStimulus(32'd40, 32'd8, acc);
      while (cycleCount < acc + 4) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      wr0 = wrCount;
      #1;
      checkCount++;
      if ({bus.mem_rd_en, bus.mem_wr_en} !== 2'b00)
         $display("[TB] FAIL rstmid_strobes got %b want 00", {bus.mem_rd_en, bus.mem_wr_en});
      else passCount++;
      checkCount++;
      if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0)
         $display("[TB] FAIL rstmid_ready_busy got %b/%b want 1/0", bus.cmd_ready, bus.busy);
      else passCount++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      checkCount++;
      if (doneCount != done0 || wrCount != wr0)
         $display("[TB] FAIL rstmid_quiet got done=%0d writes=%0d want 0/0", doneCount - done0, wrCount - wr0);
      else passCount++;
      checkCount++;
      if (imageDiffs() != 0) $display("[TB] FAIL rstmid_image got %0d diffs want 0", imageDiffs());
      else passCount++;
   endtask

   task automatic test_random();
      int acc, dn;
      bit seen;
      logic [31:0] arr, len;
      mem.delete(); expMem.delete();
      for (int i = 1000; i < 1256; i++) preload(32'(i), $urandom);
      for (int n = 0; n < 1000; n++) begin
         arr = 32'(1000 + $urandom_range(0, 200));
         len = 32'($urandom_range(0, 40));
         applyModel(arr, len);
         applyStimulus(arr, len, acc);
         waitDone(int'(len) + 20, dn, seen);
         checkCount++;
         if (!seen || dn - acc != ((len == 0) ? 1 : int'(len) + 2))
            $display("[TB] FAIL rand_latency cmd %0d len %0d got %0d want %0d", n, len,
                     seen ? dn - acc : -1, (len == 0) ? 1 : int'(len) + 2);
         else passCount++;
         @(negedge clk);
         checkCount++;
         if (imageDiffs() != 0) $display("[TB] FAIL rand_image cmd %0d got %0d diffs want 0", n, imageDiffs());
         else passCount++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_length();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
